i2c_reg_sequencer: RTL and testbench
====================================

# i2c_reg_sequencer

Command-level front end for the I2C byte master: accepts one register-access command (device address, register index, length, read/write), then drives the master's control, TX-push and RX-pop ports through a pointer-write transaction and, for reads, a second read transaction. Write payload enters as a valid/ready byte stream; read bytes leave as a valid/ready byte stream. Sits between the CPU/peripheral bus logic and the master, and is the master's only controller.

## Interface
- DIVIDER, 16'd100: SCL step divider forwarded to the master (clamped to ≥1 there).
- TIMEOUT, 24'd1_000_000: max cycles in any wait-for-master state.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake.
- i_cmd_rw  in  1  1 = read, 0 = write.
- i_cmd_addr7  in  7  device address.
- i_cmd_reg  in  8  register index, always sent as the first TX byte.
- i_cmd_len  in  8  payload bytes, 0..254 (0 = pointer write only).
- i_wdata_valid / o_wdata_ready / i_wdata  in/out/in  1/1/8  write payload stream.
- o_rdata_valid / i_rdata_ready / o_rdata  out/in/out  1/1/8  read data stream.
- o_busy  out  1  state ≠ IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  registered; valid with o_done, held until next command accept.
- o_fault  out  1  sticky lockout, cleared only by i_rst.
- o_m_en, o_m_start, o_m_rw, o_m_addr7[6:0], o_m_len[7:0], o_m_divider[15:0], o_m_tx_push, o_m_tx_push_data[7:0], o_m_rx_pop, o_m_rx_flush, o_m_clr_done, o_m_clr_ack_err  out  to master.
- i_m_rx_data[7:0], i_m_rx_valid, i_m_busy, i_m_done, i_m_ack_err  in  from master.

## Operation
- o_m_en = 1, o_m_divider = DIVIDER constant; o_m_addr7 = latched address.
- States: IDLE, CLR, PUSH_REG, PUSH_DATA, START_W, WAIT_W, START_R, WAIT_R, DRAIN, DONE, ERR, FAULT.
- IDLE: o_cmd_ready = 1 (0 if o_fault). Accept latches rw/addr/reg/len, clears o_err. i_cmd_len = 255 with rw = 0 → no transaction; DONE path with o_err = 1 next cycle.
- CLR: one cycle, pulses o_m_clr_done, o_m_clr_ack_err, o_m_rx_flush.
- PUSH_REG: o_m_tx_push = 1, data = reg. Next: PUSH_DATA if write and len > 0, else START_W.
- PUSH_DATA: o_wdata_ready = 1; each valid&ready beat pushes i_wdata combinationally (o_m_tx_push = i_wdata_valid). After len beats → START_W.
- START_W: one-cycle o_m_start, o_m_rw = 0, o_m_len = write ? len+1 : 1 (8-bit, no overflow since len ≤ 254).
- WAIT_W: wait i_m_done & !i_m_busy. Then i_m_ack_err → FAULT (TX FIFO may hold unsent bytes and has no flush); else read & len > 0 → START_R; else DONE.
- START_R: o_m_start, o_m_rw = 1, o_m_len = len. WAIT_R: on done, i_m_ack_err → ERR, else DRAIN.
- DRAIN: o_rdata = i_m_rx_data, o_rdata_valid = i_m_rx_valid; o_m_rx_pop = valid & i_rdata_ready; 8-bit count; count reaching len → DONE. i_m_rx_valid = 0 with count < len → ERR.
- DONE: o_done = 1, → IDLE. ERR: o_done = 1, o_err = 1, → IDLE. FAULT: o_done = 1 and o_err = 1 for one cycle on entry, o_fault = 1, remain in FAULT.
- Timeout: 24-bit counter reset on entry to WAIT_W/WAIT_R; reaching TIMEOUT → FAULT.
- o_m_tx_push / o_m_rx_pop never asserted while i_m_busy.

## Timing
- Reset: state IDLE; o_cmd_ready = 1; all other outputs 0 (o_m_en = 1, o_m_divider = DIVIDER).
- Read command accepted at edge 0: CLR cycle 1, PUSH_REG cycle 2, o_m_start cycle 3.
- Write: PUSH_DATA begins cycle 3, ≥1 cycle per beat; o_m_start one cycle after last beat.
- Master done sampled in WAIT state → next state entered following edge; o_done one cycle after last pop or final done.
- Pops back-to-back allowed; new head visible the cycle after pop.
- i_rst mid-operation: sequencer returns to IDLE immediately; master must share i_rst.

## Test plan
- Read addr 0x50 reg 0x10 len 2, slave model returns 0xA5, 0x3C, i_rdata_ready = 1 → TX bytes 0xA0, 0x10 STOP, then 0xA1 read; o_rdata 0xA5 then 0x3C; o_done with o_err = 0.
- Write addr 0x3C reg 0x01 len 3 data 0x11, 0x22, 0x33 with i_wdata_valid gaps → master o_m_len = 4, bus bytes 0x78, 0x01, 0x11, 0x22, 0x33; o_done, o_err = 0.
- Pointer ACKed, read address NACKed → o_done, o_err = 1, o_fault = 0; next command accepted normally.
- Write with data NACK → o_err = 1, o_fault = 1, o_cmd_ready = 0 until i_rst.
- Read len 4 with i_rdata_ready low 10 cycles between beats → no byte lost or duplicated; TIMEOUT = 50 with divider 100 → o_fault = 1.
- i_rst asserted during PUSH_DATA, then write len 255 → immediate o_done, o_err = 1, o_m_start never asserted.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// Register-access command sequencer driving an I2C byte master: pointer write of the
// register index (plus optional payload), then an optional read transaction drained to a byte stream.
module i2c_reg_sequencer #(
    parameter logic [15:0] DIVIDER = 16'd100,
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_rw,
    input  logic [6:0]  i_cmd_addr7,
    input  logic [7:0]  i_cmd_reg,
    input  logic [7:0]  i_cmd_len,
    input  logic        i_wdata_valid,
    output logic        o_wdata_ready,
    input  logic [7:0]  i_wdata,
    output logic        o_rdata_valid,
    input  logic        i_rdata_ready,
    output logic [7:0]  o_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_fault,
    output logic        o_m_en,
    output logic        o_m_start,
    output logic        o_m_rw,
    output logic [6:0]  o_m_addr7,
    output logic [7:0]  o_m_len,
    output logic [15:0] o_m_divider,
    output logic        o_m_tx_push,
    output logic [7:0]  o_m_tx_push_data,
    output logic        o_m_rx_pop,
    output logic        o_m_rx_flush,
    output logic        o_m_clr_done,
    output logic        o_m_clr_ack_err,
    input  logic [7:0]  i_m_rx_data,
    input  logic        i_m_rx_valid,
    input  logic        i_m_busy,
    input  logic        i_m_done,
    input  logic        i_m_ack_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_PUSH_REG, S_PUSH_DATA, S_START_W, S_WAIT_W,
        S_START_R, S_WAIT_R, S_DRAIN, S_DONE, S_ERR, S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        fault_q, fault_d;
    logic        fault_pulse_q, fault_pulse_d;
    logic        master_idle_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            rw_q          <= 1'b0;
            addr_q        <= 7'h00;
            reg_q         <= 8'h00;
            len_q         <= 8'h00;
            cnt_q         <= 8'h00;
            tmo_q         <= 24'h000000;
            err_q         <= 1'b0;
            fault_q       <= 1'b0;
            fault_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            reg_q         <= reg_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            fault_q       <= fault_d;
            fault_pulse_q <= fault_pulse_d;
        end
    end

    assign o_m_en           = 1'b1;
    assign o_m_divider      = DIVIDER;
    assign o_m_addr7        = addr_q;
    assign o_busy           = (state_q != S_IDLE);
    assign o_err            = err_q;
    assign o_fault          = fault_q;
    assign master_idle_done = i_m_done & ~i_m_busy;

    always_comb begin
        state_d          = state_q;
        rw_d             = rw_q;
        addr_d           = addr_q;
        reg_d            = reg_q;
        len_d            = len_q;
        cnt_d            = cnt_q;
        tmo_d            = tmo_q + 24'd1;
        err_d            = err_q;
        o_cmd_ready      = 1'b0;
        o_wdata_ready    = 1'b0;
        o_rdata_valid    = 1'b0;
        o_rdata          = 8'h00;
        o_done           = 1'b0;
        o_m_start        = 1'b0;
        o_m_rw           = 1'b0;
        o_m_len          = 8'h00;
        o_m_tx_push      = 1'b0;
        o_m_tx_push_data = 8'h00;
        o_m_rx_pop       = 1'b0;
        o_m_rx_flush     = 1'b0;
        o_m_clr_done     = 1'b0;
        o_m_clr_ack_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_cmd_ready = ~fault_q;
                if (i_cmd_valid && !fault_q) begin
                    rw_d   = i_cmd_rw;
                    addr_d = i_cmd_addr7;
                    reg_d  = i_cmd_reg;
                    len_d  = i_cmd_len;
                    cnt_d  = 8'h00;
                    err_d  = 1'b0;
                    // A 255-byte write cannot fit the master's 8-bit length once the index byte is added.
                    state_d = (!i_cmd_rw && i_cmd_len == 8'hFF) ? S_ERR : S_CLR;
                end
            end
            S_CLR: begin
                o_m_clr_done    = 1'b1;
                o_m_clr_ack_err = 1'b1;
                o_m_rx_flush    = 1'b1;
                state_d         = S_PUSH_REG;
            end
            S_PUSH_REG: begin
                o_m_tx_push_data = reg_q;
                if (!i_m_busy) begin
                    o_m_tx_push = 1'b1;
                    state_d     = (!rw_q && len_q != 8'h00) ? S_PUSH_DATA : S_START_W;
                end
            end
            S_PUSH_DATA: begin
                o_wdata_ready    = ~i_m_busy;
                o_m_tx_push      = i_wdata_valid & ~i_m_busy;
                o_m_tx_push_data = i_wdata;
                if (i_wdata_valid && !i_m_busy) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = S_START_W;
                    end
                end
            end
            S_START_W: begin
                o_m_start = 1'b1;
                o_m_len   = rw_q ? 8'd1 : len_q + 8'd1;
                tmo_d     = 24'h000000;
                state_d   = S_WAIT_W;
            end
            S_WAIT_W: begin
                if (master_idle_done) begin
                    // A NACK here can strand payload in the master's TX FIFO, which has no flush.
                    if (i_m_ack_err) begin
                        state_d = S_FAULT;
                    end else if (rw_q && len_q != 8'h00) begin
                        state_d = S_START_R;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (tmo_q >= TIMEOUT - 24'd1) begin
                    state_d = S_FAULT;
                end
            end
            S_START_R: begin
                o_m_start = 1'b1;
                o_m_rw    = 1'b1;
                o_m_len   = len_q;
                cnt_d     = 8'h00;
                tmo_d     = 24'h000000;
                state_d   = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (master_idle_done) begin
                    state_d = i_m_ack_err ? S_ERR : S_DRAIN;
                end else if (tmo_q >= TIMEOUT - 24'd1) begin
                    state_d = S_FAULT;
                end
            end
            S_DRAIN: begin
                o_rdata       = i_m_rx_data;
                o_rdata_valid = i_m_rx_valid;
                o_m_rx_pop    = i_m_rx_valid & i_rdata_ready & ~i_m_busy;
                if (!i_m_rx_valid) begin
                    state_d = S_ERR;
                end else if (i_rdata_ready && !i_m_busy) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                o_done = fault_pulse_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fault_pulse_d = (state_d == S_FAULT) && (state_q != S_FAULT);
        fault_d       = fault_q | fault_pulse_d;
        if (state_d == S_ERR || fault_pulse_d) begin
            err_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural byte-master model, directed and random
// register commands, checked against expected bus bytes / read stream computed from the command.
module tb_i2c_reg_sequencer;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic cmd_valid, cmd_rw, cmd_ready;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_reg, cmd_len;
    logic wdata_valid, wdata_ready, rdata_valid, rdata_ready;
    logic [7:0] wdata, rdata;
    logic busy, done, err, fault;
    logic m_en, m_start, m_rw, tx_push, rx_pop, rx_flush, clr_done, clr_ack;
    logic [6:0] m_addr7;
    logic [7:0] m_len, tx_data, m_rx_data;
    logic [15:0] m_div;
    logic m_rx_valid, m_busy, m_done, m_ack_err;

    i2c_reg_sequencer #(.DIVIDER(16'd100), .TIMEOUT(24'd50)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rw(cmd_rw),
        .i_cmd_addr7(cmd_addr), .i_cmd_reg(cmd_reg), .i_cmd_len(cmd_len),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
        .o_rdata_valid(rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(rdata),
        .o_busy(busy), .o_done(done), .o_err(err), .o_fault(fault),
        .o_m_en(m_en), .o_m_start(m_start), .o_m_rw(m_rw), .o_m_addr7(m_addr7),
        .o_m_len(m_len), .o_m_divider(m_div), .o_m_tx_push(tx_push),
        .o_m_tx_push_data(tx_data), .o_m_rx_pop(rx_pop), .o_m_rx_flush(rx_flush),
        .o_m_clr_done(clr_done), .o_m_clr_ack_err(clr_ack),
        .i_m_rx_data(m_rx_data), .i_m_rx_valid(m_rx_valid), .i_m_busy(m_busy),
        .i_m_done(m_done), .i_m_ack_err(m_ack_err)
    );

    // ---------------- behavioural byte master + slave ----------------
    bq_t tx_q, rx_q, slave_q, bus_log, lens_log;
    bit  busy_s, done_s, ack_s;
    bit  nack_r = 0, nack_w = 0, hang = 0;
    int  m_cnt, slave_idx = 0;
    logic m_rw_l;
    logic [7:0] m_len_l;
    logic [6:0] m_addr_l;

    always @(posedge clk) begin
        if (rst) begin
            tx_q.delete(); rx_q.delete();
            busy_s = 0; done_s = 0; ack_s = 0; m_cnt = 0;
        end else begin
            if (tx_push) tx_q.push_back(tx_data);
            if (rx_pop && rx_q.size() != 0) void'(rx_q.pop_front());
            if (rx_flush) rx_q.delete();
            if (clr_done) done_s = 0;
            if (clr_ack) ack_s = 0;
            if (m_start) begin
                busy_s = 1; done_s = 0;
                m_rw_l = m_rw; m_len_l = m_len; m_addr_l = m_addr7;
                m_cnt = 4 + int'(m_len);
                lens_log.push_back(m_len);
            end else if (busy_s && !hang) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    busy_s = 0; done_s = 1;
                    if (!m_rw_l) begin
                        bus_log.push_back({m_addr_l, 1'b0});
                        if (nack_w) ack_s = 1;
                        else for (int i = 0; i < int'(m_len_l) && tx_q.size() != 0; i++)
                            bus_log.push_back(tx_q.pop_front());
                    end else begin
                        bus_log.push_back({m_addr_l, 1'b1});
                        if (nack_r) ack_s = 1;
                        else for (int i = 0; i < int'(m_len_l) && slave_idx < slave_q.size(); i++) begin
                            rx_q.push_back(slave_q[slave_idx]);
                            slave_idx++;
                        end
                    end
                end
            end
        end
        m_busy     <= busy_s;
        m_done     <= done_s;
        m_ack_err  <= ack_s;
        m_rx_valid <= (rx_q.size() != 0);
        m_rx_data  <= (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    // ---------------- monitor ----------------
    int   cyc = 0, done_cnt = 0, start_cnt = 0, viol = 0, done_cyc = -1, last_pop_cyc = -1;
    int   start_cyc_q[$];
    bq_t  rd_log;
    logic done_err = 1'b0, done_fault = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            if (done) begin done_cnt++; done_cyc = cyc; done_err = err; done_fault = fault; end
            if (m_start) begin start_cnt++; start_cyc_q.push_back(cyc); end
            if (rdata_valid && rdata_ready) rd_log.push_back(rdata);
            if (rx_pop) last_pop_cyc = cyc;
            if ((tx_push || rx_pop) && m_busy) viol++;
        end
        cyc++;
    end

    // ---------------- checking ----------------
    int errors = 0, checks = 0, txn = 0, last_acc = 0;
    bq_t wq, cur_slave, exp_bus, exp_rd, exp_lens;
    bit  exp_err, exp_fault;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_eq(input bq_t got, input int base, input bq_t exp);
        if (got.size() - base != exp.size()) return 32'd0;
        foreach (exp[i]) if (got[base + i] !== exp[i]) return 32'd0;
        return 32'd1;
    endfunction

    // Expected outcome derived from the command alone.
    function automatic void model(input logic rw, input logic [6:0] addr, input logic [7:0] rg,
                                  input logic [7:0] len);
        exp_bus.delete(); exp_rd.delete(); exp_lens.delete();
        exp_err = 0; exp_fault = 0;
        if (!rw && len == 8'd255) begin exp_err = 1; return; end
        exp_lens.push_back(rw ? 8'd1 : len + 8'd1);
        exp_bus.push_back({addr, 1'b0});
        exp_bus.push_back(rg);
        if (hang) begin exp_err = 1; exp_fault = 1; return; end
        if (!rw) begin
            if (nack_w) begin exp_err = 1; exp_fault = 1; end
            foreach (wq[i]) exp_bus.push_back(wq[i]);
            return;
        end
        if (len == 8'd0) return;
        exp_lens.push_back(len);
        exp_bus.push_back({addr, 1'b1});
        if (nack_r) exp_err = 1;
        else foreach (cur_slave[i]) exp_rd.push_back(cur_slave[i]);
    endfunction

    task automatic prep_slave(input int n);
        logic [7:0] b;
        cur_slave.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            cur_slave.push_back(b);
            slave_q.push_back(b);
        end
    endtask

    task automatic run_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] rg,
                           input logic [7:0] len, input int gap_w, input int gap_r, input bit chk_bus);
        int dc0, bb, rb, lb, sb, widx, rgap;
        dc0 = done_cnt; bb = bus_log.size(); rb = rd_log.size();
        lb = lens_log.size(); sb = start_cyc_q.size();
        widx = 0; rgap = 0;
        model(rw, addr, rg, len);
        @(negedge clk);
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1; cmd_rw = rw; cmd_addr = addr; cmd_reg = rg; cmd_len = len;
        last_acc = cyc;
        @(negedge clk);
        cmd_valid = 0;
        for (int b = 0; b < 3000 && done_cnt == dc0; b++) begin
            if (widx < wq.size() && $urandom_range(0, gap_w) == 0) begin
                wdata_valid = 1; wdata = wq[widx];
                if (wdata_ready) widx++;
            end else begin
                wdata_valid = 0;
            end
            if (gap_r == 0) rdata_ready = 1;
            else begin
                rdata_ready = (rgap == 0);
                if (rdata_valid && rdata_ready) rgap = gap_r;
                else if (rgap > 0) rgap--;
            end
            @(negedge clk);
        end
        wdata_valid = 0; rdata_ready = 0;
        chk("done_seen", 32'(done_cnt - dc0), 32'd1);
        chk("err", 32'(done_err), 32'(exp_err));
        chk("fault", 32'(done_fault), 32'(exp_fault));
        chk("err_hold", 32'(err), 32'(exp_err));
        if (chk_bus) begin
            chk("bus_bytes", q_eq(bus_log, bb, exp_bus), 32'd1);
            chk("master_len", q_eq(lens_log, lb, exp_lens), 32'd1);
            chk("rdata_stream", q_eq(rd_log, rb, exp_rd), 32'd1);
        end
        if (rw && exp_rd.size() != 0 && start_cyc_q.size() > sb) begin
            chk("read_start_lat", 32'(start_cyc_q[sb] - last_acc), 32'd3);
            chk("done_after_pop", 32'(done_cyc - last_pop_cyc), 32'd1);
        end
        if (!rw && gap_w == 0 && len != 8'd255 && !exp_fault && start_cyc_q.size() > sb)
            chk("write_start_lat", 32'(start_cyc_q[sb] - last_acc), 32'(int'(len) + 3));
        $display("txn %0d rw=%0d addr=%02h reg=%02h len=%0d err=%0d fault=%0d rbytes=%0d",
                 txn, rw, addr, rg, len, done_err, done_fault, rd_log.size() - rb);
        txn++;
    endtask

    initial begin
        logic rw;
        logic [6:0] ra;
        logic [7:0] rr, rl;
        int s0;
        rst = 1; cmd_valid = 0; cmd_rw = 0; cmd_addr = 0; cmd_reg = 0; cmd_len = 0;
        wdata_valid = 0; wdata = 0; rdata_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_fault", 32'({err, fault}), 32'd0);
        chk("rst_m_en", 32'(m_en), 32'd1);
        chk("rst_divider", 32'(m_div), 32'd100);
        chk("rst_m_ctrl", 32'({m_start, tx_push, rx_pop, rx_flush, clr_done, clr_ack}), 32'd0);
        chk("rst_streams", 32'({wdata_ready, rdata_valid}), 32'd0);
        rst = 0;

        wq.delete();
        cur_slave.delete();
        cur_slave.push_back(8'hA5); cur_slave.push_back(8'h3C);
        slave_q.push_back(8'hA5); slave_q.push_back(8'h3C);
        run_cmd(1'b1, 7'h50, 8'h10, 8'd2, 0, 0, 1);

        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
        run_cmd(1'b0, 7'h3C, 8'h01, 8'd3, 2, 0, 1);

        for (int t = 0; t < 8; t++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 7'($urandom); rr = 8'($urandom); rl = 8'($urandom_range(0, 6));
            wq.delete();
            if (rw) prep_slave(int'(rl));
            else for (int i = 0; i < int'(rl); i++) wq.push_back(8'($urandom));
            run_cmd(rw, ra, rr, rl, $urandom_range(0, 2), $urandom_range(0, 3), 1);
        end

        // read address NACK is a recoverable error
        wq.delete(); nack_r = 1;
        run_cmd(1'b1, 7'h22, 8'h05, 8'd2, 0, 0, 1);
        nack_r = 0;
        prep_slave(3);
        run_cmd(1'b1, 7'h22, 8'h06, 8'd3, 0, 0, 1);

        // slow consumer
        prep_slave(4);
        run_cmd(1'b1, 7'h11, 8'h20, 8'd4, 0, 10, 1);

        // write data NACK locks the sequencer until reset
        wq.delete(); wq.push_back(8'h5A); wq.push_back(8'hC3); nack_w = 1;
        run_cmd(1'b0, 7'h3C, 8'h02, 8'd2, 0, 0, 0);
        nack_w = 0;
        repeat (4) @(negedge clk);
        chk("fault_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("fault_sticky", 32'(fault), 32'd1);
        rst = 1; @(negedge clk); rst = 0;
        chk("fault_cleared", 32'({fault, err}), 32'd0);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // reset while waiting for write payload
        wq.delete();
        @(negedge clk);
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 7'h3C; cmd_reg = 8'h09; cmd_len = 8'd3;
        @(negedge clk);
        cmd_valid = 0;
        repeat (2) @(negedge clk);
        chk("push_data_ready", 32'(wdata_ready), 32'd1);
        rst = 1; @(negedge clk); rst = 0;
        chk("midrst_idle", 32'({busy, wdata_ready}), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);

        s0 = start_cnt;
        run_cmd(1'b0, 7'h3C, 8'h07, 8'd255, 0, 0, 1);
        chk("len255_no_start", 32'(start_cnt - s0), 32'd0);
        chk("len255_done_lat", 32'(done_cyc - last_acc), 32'd1);

        // master never completes -> timeout fault
        hang = 1;
        run_cmd(1'b1, 7'h50, 8'h10, 8'd2, 0, 0, 0);
        @(negedge clk);
        chk("timeout_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("timeout_no_done_repeat", 32'(done), 32'd0);
        hang = 0;
        rst = 1; @(negedge clk); rst = 0;
        @(negedge clk);

        chk("no_push_pop_while_busy", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
